// File: rtl/mealey_arbiter_pkg.sv
// Shared types for the round-robin burst arbiter in front of the Mealey datapath.
package mealey_arb_types;

    localparam int SAMPLE_W = 9;
    localparam int TAG_ID_W = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam tag_t TAG_NONE = '{vld: 1'b0, id: 4'd0};

    // Requester id width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mealey_arbiter_rr_pick.sv
// Rotate-priority picker: first requester found scanning upward from start, wrapping mod N.
module mealey_arb_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic            found,
    output logic [ID_W-1:0] win
);

    int   idx;
    logic hit;

    // Linear scan; the start lane has the highest priority.
    always_comb begin
        found = 1'b0;
        win   = {ID_W{1'b0}};
        idx   = 0;
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx   = (int'(start) + k) % N;
            hit   = !found && req[idx];
            win   = hit ? ID_W'(idx) : win;
            found = found | req[idx];
        end
    end

endmodule

// File: rtl/mealey_arbiter.sv
// Round-robin burst arbiter sharing one Mealey_topEntity datapath between N requesters,
// tagging each datapath result with the id of the requester that issued it.
module mealey_arbiter
    import mealey_arb_types::*;
#(
    parameter int      N          = 4,
    parameter int      BURST      = 4,
    parameter int      DP_LAT     = 0,
    parameter sample_t IDLE_VALUE = 9'sd0,
    localparam int     ID_W       = id_width(N)
) (
    input  logic                         system1000,
    input  logic                         system1000_rstn,
    input  logic [N-1:0]                 req_valid,
    input  logic signed [N*SAMPLE_W-1:0] req_data,
    output logic [N-1:0]                 req_ready,
    output sample_t                      dp_in,
    input  sample_t                      dp_out,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output sample_t                      rsp_data
);

    localparam logic [3:0] BURST_C = 4'(BURST);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] own_q, own_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [ID_W-1:0] pick_base_s, pick_start_s, pick_win_s;
    logic            pick_found_s;
    logic            rotate_s;
    logic            grant_s;
    logic [ID_W-1:0] grant_id_s;

    sample_t         dp_in_q, dp_in_d;
    tag_t            tag_d;
    tag_t            tag_q [0:DP_LAT];
    tag_t            tag_out_s;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    sample_t         rsp_data_q, rsp_data_d;

    mealey_arb_rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req   (req_valid),
        .start (pick_start_s),
        .found (pick_found_s),
        .win   (pick_win_s)
    );

    // Rotation condition and picker start: one past the owner, or one past the last owner when idle.
    always_comb begin
        rotate_s     = (state_q == GRANT) && (!req_valid[own_q] || (cnt_q >= BURST_C));
        pick_base_s  = (state_q == GRANT) ? own_q : last_q;
        pick_start_s = (pick_base_s == ID_W'(N-1)) ? {ID_W{1'b0}} : pick_base_s + ID_W'(1);
    end

    // FSM state register.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= IDLE;
            own_q   <= {ID_W{1'b0}};
            last_q  <= ID_W'(N-1);
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state; a rotation hands over in the same cycle so there is no dead beat.
    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        grant_s    = 1'b0;
        grant_id_s = own_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    grant_s    = 1'b1;
                    grant_id_s = pick_win_s;
                    state_d    = GRANT;
                    own_d      = pick_win_s;
                    cnt_d      = 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!rotate_s) begin
                    grant_s = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                end else if (pick_found_s) begin
                    last_d     = own_q;
                    grant_s    = 1'b1;
                    grant_id_s = pick_win_s;
                    own_d      = pick_win_s;
                    cnt_d      = 4'd1;
                end else begin
                    last_d  = own_q;
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM outputs: one-hot ready, datapath sample and the tag entering the pipe.
    always_comb begin
        req_ready = {N{1'b0}};
        dp_in_d   = IDLE_VALUE;
        tag_d     = TAG_NONE;
        if (grant_s) begin
            req_ready[grant_id_s] = 1'b1;
            dp_in_d               = req_data[SAMPLE_W*int'(grant_id_s) +: SAMPLE_W];
            tag_d                 = '{vld: 1'b1, id: TAG_ID_W'(grant_id_s)};
        end else begin
            req_ready = {N{1'b0}};
        end
    end

    // Response capture; data holds its last value between responses.
    always_comb begin
        tag_out_s   = tag_q[DP_LAT];
        rsp_valid_d = tag_out_s.vld;
        rsp_id_d    = ID_W'(tag_out_s.id);
        if (tag_out_s.vld) begin
            rsp_data_d = dp_out;
        end else begin
            rsp_data_d = rsp_data_q;
        end
    end

    // Datapath input register, tag pipe matching datapath latency, and response registers.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            dp_in_q     <= IDLE_VALUE;
            for (int i = 0; i <= DP_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= {ID_W{1'b0}};
            rsp_data_q  <= 9'sd0;
        end else begin
            dp_in_q  <= dp_in_d;
            tag_q[0] <= tag_d;
            for (int i = 1; i <= DP_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign dp_in     = dp_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mealey_arbiter.sv
// Scoreboard bench for mealey_arbiter: a behavioural arbitration model predicts grants and
// responses; a monitor pops the expected responses whenever rsp_valid is seen.
module tb_mealey_arbiter;

    localparam int N      = 4;
    localparam int BURST  = 4;
    localparam int DP_LAT = 3;
    localparam logic signed [8:0] IDLE_V = 9'sd0;
    localparam logic [8:0]        XK     = 9'h0A5;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N-1:0]            req_valid = '0;
    logic [N*9-1:0]          req_data = '0;
    logic [N-1:0]            req_ready;
    logic signed [8:0]       dp_in;
    logic signed [8:0]       dp_out;
    logic                    rsp_valid;
    logic [1:0]              rsp_id;
    logic signed [8:0]       rsp_data;

    mealey_arbiter #(.N(N), .BURST(BURST), .DP_LAT(DP_LAT), .IDLE_VALUE(IDLE_V)) dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .dp_in           (dp_in),
        .dp_out          (dp_out),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: DP_LAT register stages then a fixed XOR.
    logic signed [8:0] dp_pipe [0:DP_LAT-1];
    always @(posedge clk) begin
        dp_pipe[0] <= dp_in;
        for (int i = 1; i < DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_out = dp_pipe[DP_LAT-1] ^ XK;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; int id; int data; } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_own  = -1;
    int m_cnt  = 0;
    int m_last = N - 1;
    logic signed [8:0] exp_dp = IDLE_V;

    bit seq_on = 0;
    int seq_k  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Arbitration rules: keep the owner while it is valid and under its burst, otherwise
    // scan upward from one past the previous owner, which therefore competes last.
    task automatic model_step(input logic [N-1:0] v, output int g);
        if (m_own >= 0 && v[m_own] && m_cnt < BURST) begin
            g = m_own;
            m_cnt++;
        end else begin
            if (m_own >= 0) m_last = m_own;
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (g < 0 && v[c]) g = c;
            end
            if (g >= 0) begin
                m_own = g;
                m_cnt = 1;
            end else begin
                m_own = -1;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*9-1:0] d);
        int g;
        logic [N-1:0] one;
        logic [N-1:0] exp_rdy;
        logic signed [8:0] lane;
        logic signed [8:0] res;
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = d;
        @(negedge clk);
        check("dp_in", int'(dp_in), int'(exp_dp));
        model_step(v, g);
        one = 1;
        exp_rdy = (g >= 0) ? (one << g) : '0;
        check("req_ready", int'(req_ready), int'(exp_rdy));
        if (seq_on && g >= 0) begin
            check("burst_seq", int'(req_ready), int'(one << ((seq_k / BURST) % N)));
            seq_k++;
        end
        if (g >= 0) begin
            lane = d[9*g +: 9];
            res  = lane ^ XK;
            sb_q.push_back('{cyc + 2 + DP_LAT, g, int'(res)});
            exp_dp = lane;
        end else begin
            exp_dp = IDLE_V;
        end
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        sb_q.delete();
        m_own  = -1;
        m_cnt  = 0;
        m_last = N - 1;
        exp_dp = IDLE_V;
        #1;
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_dp_in", int'(dp_in), int'(IDLE_V));
        check("rst_rsp_id", int'(rsp_id), 0);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [N*9-1:0] tp_lanes();
        logic [N*9-1:0] d;
        for (int i = 0; i < N; i++) d[9*i +: 9] = 9'(10 * i + 1);
        return d;
    endfunction

    function automatic logic [N*9-1:0] rand_lanes();
        logic [N*9-1:0] d;
        for (int i = 0; i < N; i++) d[9*i +: 9] = 9'($urandom);
        return d;
    endfunction

    // Monitor: every response must match the oldest outstanding beat, at its due cycle.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_cycle", cyc, mon_e.due);
                check("rsp_id", int'(rsp_id), mon_e.id);
                check("rsp_data", int'(rsp_data), mon_e.data);
            end
        end
    end

    initial begin
        logic [N-1:0] v;
        logic [N*9-1:0] d;
        logic [3:0] tog;

        do_reset(3);

        // All requesters valid straight out of reset: 0,0,0,0,1,1,1,1,...
        seq_on = 1;
        seq_k  = 0;
        for (int c = 0; c < 20; c++) step('1, tp_lanes());
        seq_on = 0;

        // Only requester 2, toggling 1,1,0,1.
        tog = 4'b1011;
        for (int c = 0; c < 8; c++) begin
            v = '0;
            v[2] = tog[c % 4];
            step(v, rand_lanes());
        end

        // Requester 1 continuous, requester 3 joins midway.
        for (int c = 0; c < 16; c++) begin
            v = '0;
            v[1] = 1'b1;
            v[3] = (c >= 3);
            step(v, rand_lanes());
        end

        // Single beat of -256 from requester 0, then drain.
        d = rand_lanes();
        d[8:0] = 9'h100;
        step(4'b0001, d);
        for (int c = 0; c < 8; c++) step('0, rand_lanes());

        // Three beats, reset while in flight, then restart from requester 0.
        for (int c = 0; c < 3; c++) step('1, rand_lanes());
        do_reset(2);
        for (int c = 0; c < 10; c++) step('0, rand_lanes());
        seq_on = 1;
        seq_k  = 0;
        for (int c = 0; c < 4; c++) step('1, rand_lanes());
        seq_on = 0;

        // All idle.
        for (int c = 0; c < 10; c++) step('0, rand_lanes());

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 3) != 0);
            step(v, rand_lanes());
        end

        for (int c = 0; c < DP_LAT + 6; c++) step('0, rand_lanes());
        check("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
